// File: rtl/prio_enc_disp_pkg.sv
// Shared constants for prio_enc_disp: active-low seven-segment patterns.
// Segment bit order is {g,f,e,d,c,b,a}.
package prio_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000
    };

    function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
        logic [6:0] s;
        s = SEG_BLANK;
        if (d <= 4'd9) s = SEG_DIGIT[d];
        return s;
    endfunction

endpackage

// File: rtl/prio_enc_disp_if.sv
// Request/readout bundle of prio_enc_disp.
// master drives en/x, slave (the encoder) drives the readout.
interface prio_enc_disp_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 2
);
    localparam int IDXW = $clog2(WIDTH);

    logic                  en;
    logic [WIDTH-1:0]      x;
    logic                  valid;
    logic [IDXW-1:0]       idx;
    logic                  changed;
    logic [7*DIGITS-1:0]   seg;
    logic                  seg_busy;

    modport master (
        output en, x,
        input  valid, idx, changed, seg, seg_busy
    );

    modport slave (
        input  en, x,
        output valid, idx, changed, seg, seg_busy
    );

endinterface

// File: rtl/prio_enc_disp_bin2bcd_seq.sv
// Iterative shift/add-3 binary-to-BCD converter, one bit per enabled cycle.
// done_o marks the final iteration edge; bcd_o carries that edge's result.
module bin2bcd_seq #(
    parameter int IDXW   = 4,
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic                start_i,
    input  logic [IDXW-1:0]     bin_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [4*DIGITS-1:0] bcd_o
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IDXW + 1);

    logic [IDXW-1:0] sh_q, sh_d;
    logic [BW-1:0]   bcd_q, bcd_d, adj;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] > 4'd4)
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_d = {adj[BW-2:0], sh_q[IDXW-1]};
        sh_d  = sh_q << 1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (en_i) begin
            if (start_i) begin
                sh_q   <= bin_i;
                bcd_q  <= '0;
                cnt_q  <= CW'(IDXW);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                sh_q   <= sh_d;
                bcd_q  <= bcd_d;
                cnt_q  <= cnt_q - CW'(1);
                busy_q <= (cnt_q != CW'(1));
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = en_i && !start_i && busy_q && (cnt_q == CW'(1));
    assign bcd_o  = bcd_d;

endmodule

// File: rtl/prio_enc_disp.sv
// Debounced priority encoder with decimal seven-segment readout.
// Macro PRIO_ENC_DEBOUNCE_EN enables the input stability filter.
module prio_enc_disp
    import prio_disp_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DIGITS   = 2,
    parameter int DEBOUNCE = 4
) (
    input logic            clk,
    input logic            rst_n,
    prio_enc_disp_if.slave bus
);
    localparam int IDXW = $clog2(WIDTH);

    logic [WIDTH-1:0]    vec;
    logic                commit, start, diff;
    logic                valid_q, valid_d, changed_q;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [7*DIGITS-1:0] seg_q, seg_d;
    logic                cv_busy, cv_done;
    logic [4*DIGITS-1:0] cv_bcd;

`ifdef PRIO_ENC_DEBOUNCE_EN
    localparam int CNTW = $clog2(DEBOUNCE + 1);

    logic [WIDTH-1:0] x_c_q;
    logic [CNTW-1:0]  cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_c_q <= '0;
            cnt_q <= '0;
        end else if (bus.en) begin
            if (bus.x != x_c_q) begin
                x_c_q <= bus.x;
                cnt_q <= '0;
            end else if (cnt_q < CNTW'(DEBOUNCE)) begin
                cnt_q <= cnt_q + CNTW'(1);
            end
        end
    end

    assign vec    = x_c_q;
    assign commit = bus.en && (bus.x == x_c_q)
                  && (cnt_q == CNTW'(DEBOUNCE - 1));
    assign start  = commit;
`else
    logic unused_deb;
    assign unused_deb = |DEBOUNCE;

    assign vec    = bus.x;
    assign commit = bus.en;
    // A held input commits every edge; only a new value restarts conversion.
    assign start  = commit && diff;
`endif

    always_comb begin
        idx_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) idx_d = IDXW'(i);
        end
        valid_d = |vec;
        diff    = {valid_d, idx_d} != {valid_q, idx_q};
    end

    bin2bcd_seq #(
        .IDXW   (IDXW),
        .DIGITS (DIGITS)
    ) u_bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (bus.en),
        .start_i (start),
        .bin_i   (idx_d),
        .busy_o  (cv_busy),
        .done_o  (cv_done),
        .bcd_o   (cv_bcd)
    );

    // Blank leading zeros; digit 0 always shows a value.
    always_comb begin
        logic       lead;
        logic [3:0] d;
        lead  = 1'b1;
        d     = '0;
        seg_d = {DIGITS{SEG_DASH}};
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = cv_bcd[4*i +: 4];
            if (lead && d == 4'd0 && i != 0) begin
                seg_d[7*i +: 7] = SEG_BLANK;
            end else begin
                lead = 1'b0;
                seg_d[7*i +: 7] = digit_to_seg(d);
            end
        end
        if (!valid_q) seg_d = {DIGITS{SEG_DASH}};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            idx_q     <= '0;
            changed_q <= 1'b0;
            seg_q     <= {DIGITS{SEG_DASH}};
        end else begin
            changed_q <= commit && diff;
            if (commit) begin
                valid_q <= valid_d;
                idx_q   <= idx_d;
            end
            if (cv_done) seg_q <= seg_d;
        end
    end

    assign bus.valid    = valid_q;
    assign bus.idx      = idx_q;
    assign bus.changed  = changed_q;
    assign bus.seg      = seg_q;
    assign bus.seg_busy = cv_busy;

endmodule
